reduce_nway_pipe: RTL and testbench

//  Parametrised, pipelined N-way bit reduction: the registered successor to the 8-way OR gate.

---
 rtl/reduce_pkg.sv | 25 ++
 rtl/reduce_stage.sv | 61 ++++++
 rtl/reduce_nway_pipe.sv | 69 ++++++
 tb/tb_reduce_nway_pipe.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/reduce_pkg.sv
// Shared op encodings and per-op helpers for the pipelined reduction tree.
package reduce_pkg;

  localparam logic [1:0] OP_OR  = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Neutral element used to pad unused lanes: only AND needs a 1.
  function automatic logic identity(input logic [1:0] op);
    return (op == OP_AND);
  endfunction

  // Two-input reduction; NOR travels through the tree as OR and is inverted at the end.
  function automatic logic reduce2(input logic a, input logic b, input logic [1:0] op);
    logic r;
    case (op)
      OP_AND:  r = a & b;
      OP_XOR:  r = a ^ b;
      default: r = a | b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/reduce_stage.sv
// One tree level: pairwise-reduces IN_W lanes into ceil(IN_W/2) registered lanes.
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int IN_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     advance,
  input  logic [IN_W-1:0]          in_data,
  input  logic [1:0]               in_op,
  input  logic                     in_valid,
  output logic [(IN_W+1)/2-1:0]    out_data,
  output logic [1:0]               out_op,
  output logic                     out_valid
);

  localparam int OUT_W = (IN_W + 1) / 2;

  logic [2*OUT_W-1:0] pad_data;
  logic [OUT_W-1:0]   red_next;
  logic [OUT_W-1:0]   data_reg;
  logic [1:0]         op_reg;
  logic               valid_reg;

  // Fill an odd trailing lane with the op's identity so it cannot disturb the result.
  always_comb begin
    pad_data = '0;
    pad_data[IN_W-1:0] = in_data;
    if (2 * OUT_W != IN_W) begin
      pad_data[2*OUT_W-1] = identity(in_op);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < OUT_W; gi++) begin : g_lane
      assign red_next[gi] = reduce2(pad_data[2*gi], pad_data[2*gi+1], in_op);
    end
  endgenerate

  // Valid moves on every advance; data/op only load for real words so bubbles leave the last result in place.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      op_reg    <= OP_OR;
    end else if (advance) begin
      valid_reg <= in_valid;
      if (in_valid) begin
        data_reg <= red_next;
        op_reg   <= in_op;
      end
    end
  end

  assign out_data  = data_reg;
  assign out_op    = op_reg;
  assign out_valid = valid_reg;

endmodule

// File: rtl/reduce_nway_pipe.sv
// Pipelined WIDTH-to-1 reduction (OR/AND/XOR/NOR) with one register per tree level
// and a valid/ready handshake; a single global advance stalls the whole pipe.
module reduce_nway_pipe
  import reduce_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic [1:0]       out_op,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int PW     = 1 << LEVELS;

  // All tree levels packed back to back: level k starts at 2*PW - (2*PW >> k) and is PW >> k wide.
  logic [2*PW-2:0] tree_data;
  logic [1:0]      lvl_op    [0:LEVELS];
  logic            lvl_valid [0:LEVELS];
  logic [PW-1:0]   pad_data;
  logic            advance;

  // Widen the input word to a power of two using the op's identity.
  always_comb begin
    pad_data = {PW{identity(in_op)}};
    pad_data[WIDTH-1:0] = in_data;
  end

  assign tree_data[PW-1:0] = pad_data;
  assign lvl_op[0]         = in_op;
  assign lvl_valid[0]      = in_valid;

  // Empty output slot or a consuming sink lets every stage move together.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  genvar gi;
  generate
    for (gi = 0; gi < LEVELS; gi++) begin : g_level
      localparam int IN_W     = PW >> gi;
      localparam int BASE_IN  = 2 * PW - ((2 * PW) >> gi);
      localparam int BASE_OUT = 2 * PW - ((2 * PW) >> (gi + 1));

      reduce_stage #(.IN_W(IN_W)) u_stage (
        .clk       (clk),
        .reset     (reset),
        .advance   (advance),
        .in_data   (tree_data[BASE_IN +: IN_W]),
        .in_op     (lvl_op[gi]),
        .in_valid  (lvl_valid[gi]),
        .out_data  (tree_data[BASE_OUT +: IN_W/2]),
        .out_op    (lvl_op[gi+1]),
        .out_valid (lvl_valid[gi+1])
      );
    end
  endgenerate

  assign out_valid = lvl_valid[LEVELS];
  assign out_op    = lvl_op[LEVELS];
  assign out_bit   = tree_data[2*PW-2] ^ (lvl_op[LEVELS] == OP_NOR);

endmodule

// File: tb/tb_reduce_nway_pipe.sv
// Directed + random bench for reduce_nway_pipe (WIDTH=8 main instance, WIDTH=5 padding instance).
module tb_reduce_nway_pipe;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic [1:0] in_op;
  logic       in_valid, in_ready, out_bit, out_valid, out_ready;
  logic [1:0] out_op;

  logic [4:0] in_data5;
  logic [1:0] in_op5, out_op5;
  logic       in_valid5, in_ready5, out_bit5, out_valid5, out_ready5;

  int checks = 0;
  int errors = 0;

  logic [2:0] sb[$];          // {expected bit, op}
  int         step_no = 0;
  int         accepted = 0;
  int         emitted = 0;
  int         first_acc = -1;
  int         first_emit = -1;
  logic       hold_prev = 1'b0;
  logic       prev_bit;
  logic [1:0] prev_op;

  logic [7:0] vals[5] = '{8'h00, 8'h01, 8'h10, 8'hFF, 8'h55};
  int exp_tab[4][5] = '{'{0,1,1,1,1}, '{0,0,0,1,0}, '{0,1,1,0,0}, '{1,0,0,0,0}};

  reduce_nway_pipe #(.WIDTH(8)) u_dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_op(in_op), .in_valid(in_valid),
    .in_ready(in_ready), .out_bit(out_bit), .out_op(out_op), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  reduce_nway_pipe #(.WIDTH(5)) u_dut5 (
    .clk(clk), .reset(reset), .in_data(in_data5), .in_op(in_op5), .in_valid(in_valid5),
    .in_ready(in_ready5), .out_bit(out_bit5), .out_op(out_op5), .out_valid(out_valid5),
    .out_ready(out_ready5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Golden reduction from the op definitions over the low w bits.
  function automatic logic ref_bit(input logic [7:0] d, input logic [1:0] op, input int w);
    logic [7:0] mask;
    logic [7:0] m;
    mask = 8'((1 << w) - 1);
    m = d & mask;
    case (op)
      2'b00:   return m != 0;
      2'b01:   return m == mask;
      2'b10:   return ($countones(m) % 2) == 1;
      default: return m == 0;
    endcase
  endfunction

  // One cycle on the WIDTH=8 instance: drive, score handshakes seen before the edge, clock.
  task automatic step(input logic v, input logic [7:0] d, input logic [1:0] op,
                      input logic rdy, input int tab);
    logic [2:0] e;
    @(negedge clk);
    in_valid = v; in_data = d; in_op = op; out_ready = rdy;
    #1;
    if (hold_prev) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_bit", out_bit, prev_bit);
      chk("hold_op", out_op, prev_op);
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_emit", out_valid, 0);
      end else begin
        e = sb.pop_front();
        chk("out_bit", out_bit, e[2]);
        chk("out_op", out_op, e[1:0]);
      end
      emitted++;
      if (first_emit < 0) first_emit = step_no;
    end
    if (in_valid && in_ready) begin
      if (tab < 0) sb.push_back({ref_bit(d, op, 8), op});
      else         sb.push_back({tab[0], op});
      accepted++;
      if (first_acc < 0) first_acc = step_no;
    end
    hold_prev = out_valid && !out_ready;
    prev_bit  = out_bit;
    prev_op   = out_op;
    step_no++;
  endtask

  // Single word through the WIDTH=5 instance with latency measurement.
  task automatic send5(input logic [4:0] d, input logic [1:0] op, input logic expb, input string tag);
    int lat;
    @(negedge clk);
    in_valid5 = 1'b1; in_data5 = d; in_op5 = op; out_ready5 = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready5, 1);
    @(negedge clk);
    in_valid5 = 1'b0;
    lat = 1;
    #1;
    while (!out_valid5 && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, lat, 3);
    chk({tag, "_bit"}, out_bit5, expb);
    chk({tag, "_op"}, out_op5, op);
  endtask

  initial begin
    int base_acc, base_emit, budget;
    logic sb_bit;
    logic [1:0] sb_op;

    reset = 1'b1;
    in_valid = 0; in_data = 0; in_op = 0; out_ready = 1;
    in_valid5 = 0; in_data5 = 0; in_op5 = 0; out_ready5 = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_bit", out_bit, 0);
    chk("rst_out_op", out_op, 0);
    chk("rst_in_ready", in_ready, 1);
    reset = 1'b0;

    // 1. Reset with three words in flight, then confirm nothing stale appears.
    for (int i = 0; i < 3; i++) step(1, 8'hFF, 2'b11, 0, -1);
    step(0, 8'h00, 2'b00, 0, -1);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_in_ready", in_ready, 0);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_bit", out_bit, 0);
    chk("async_rst_op", out_op, 0);
    sb.delete();
    hold_prev = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step(0, 8'h00, 2'b00, 1, -1);
      chk("post_rst_idle", out_valid, 0);
    end

    // 2. Op table against fixed expected results.
    for (int o = 0; o < 4; o++)
      for (int k = 0; k < 5; k++)
        step(1, vals[k], 2'(o), 1, exp_tab[o][k]);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 2'b00, 1, -1);
    chk("ops_drained", sb.size(), 0);

    // 3. Sixteen back-to-back words: latency and one-per-cycle order.
    first_acc = -1; first_emit = -1; base_acc = accepted; base_emit = emitted;
    for (int i = 0; i < 16; i++) step(1, 8'($urandom), 2'($urandom), 1, -1);
    chk("stream_accepts", accepted - base_acc, 16);
    chk("stream_latency", first_emit - first_acc, 3);
    chk("stream_emits_inflight", emitted - base_emit, 13);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 2'b00, 1, -1);
    chk("stream_drained", sb.size(), 0);

    // 4. Backpressure with a full pipe for five cycles.
    base_emit = emitted;
    for (int i = 0; i < 3; i++) step(1, 8'($urandom), 2'($urandom), 0, -1);
    for (int i = 0; i < 5; i++) begin
      step(1, 8'($urandom), 2'($urandom), 0, -1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
    end
    for (int i = 0; i < 6; i++) step(0, 8'h00, 2'b00, 1, -1);
    chk("bp_emits", emitted - base_emit, 3);
    chk("bp_drained", sb.size(), 0);

    // 5. Random traffic, 1000 words.
    base_acc = accepted; budget = 0;
    while (accepted - base_acc < 1000 && budget < 8000) begin
      step(1'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), -1);
      budget++;
    end
    chk("rand_accepts", accepted - base_acc, 1000);
    budget = 0;
    while (sb.size() != 0 && budget < 20) begin
      step(0, 8'h00, 2'b00, 1, -1);
      budget++;
    end
    chk("rand_drained", sb.size(), 0);

    // 6. Odd width: padding and latency on the WIDTH=5 instance.
    send5(5'h1F, 2'b01, ref_bit(8'h1F, 2'b01, 5), "w5_and_1f");
    send5(5'h0F, 2'b01, ref_bit(8'h0F, 2'b01, 5), "w5_and_0f");
    send5(5'h00, 2'b00, 1'b0, "w5_or_00");
    send5(5'h10, 2'b10, 1'b1, "w5_xor_10");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
